// File: rtl/reducer_request_scheduler.sv
// reducer_request_scheduler
// Shares a single Payne-Hanek reducer between two requesters. A round-robin
// arbiter picks one operand at a time. Operands the reducer cannot handle
// (Inf/NaN, or magnitudes too small for its table index) are answered
// directly. All other operands are issued once and held stable on
// red_data_in while the reducer works. A watchdog abandons a reduction whose
// out_valid never arrives. Each result leaves with its tag on one
// valid/ready port.
module reducer_request_scheduler #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             red_in_valid,
    output logic [31:0]      red_data_in,
    input  logic             red_out_valid,
    input  logic [4:0]       red_q,
    input  logic [63:0]      red_f,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_x,
    output logic [4:0]       rsp_q,
    output logic [63:0]      rsp_f,
    output logic [2:0]       rsp_flags,
    output logic             busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_reg;
    logic               rr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               red_in_valid_reg;
    logic [31:0]        red_data_in_reg;
    logic               rsp_valid_reg;
    logic               rsp_src_reg;
    logic [TAG_W-1:0]   rsp_tag_reg;
    logic [31:0]        rsp_x_reg;
    logic [4:0]         rsp_q_reg;
    logic [63:0]        rsp_f_reg;
    logic [2:0]         rsp_flags_reg;

    // Requester inputs gathered into index-addressable form
    logic [1:0]         req_valid;
    logic [31:0]        req_data [2];
    logic [TAG_W-1:0]   req_tag  [2];
    logic [1:0]         ready_vec;

    logic               idle;
    logic               grant_idx;
    logic               handshake;
    logic [31:0]        sel_data;
    logic [TAG_W-1:0]   sel_tag;
    logic [7:0]         sel_exp;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;
    assign req_tag[0]  = req0_tag;
    assign req_tag[1]  = req1_tag;

    assign idle      = (state_reg == IDLE);
    // A lone requester wins outright; contention is settled by the rr pointer
    assign grant_idx = (req_valid[0] & req_valid[1]) ? rr_reg : req_valid[1];
    assign handshake = idle & ~rst & (|req_valid);
    assign sel_data  = req_data[grant_idx];
    assign sel_tag   = req_tag[grant_idx];
    assign sel_exp   = sel_data[30:23];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = idle & ~rst & req_valid[gi] & (grant_idx == 1'(gi));
        end
    endgenerate

    assign req0_ready   = ready_vec[0];
    assign req1_ready   = ready_vec[1];
    assign busy         = (state_reg != IDLE);
    assign red_in_valid = red_in_valid_reg;
    assign red_data_in  = red_data_in_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_src      = rsp_src_reg;
    assign rsp_tag      = rsp_tag_reg;
    assign rsp_x        = rsp_x_reg;
    assign rsp_q        = rsp_q_reg;
    assign rsp_f        = rsp_f_reg;
    assign rsp_flags    = rsp_flags_reg;

    // Scheduler FSM: grant/classify, single-cycle issue, watchdog wait, hold response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            rr_reg           <= 1'b0;
            cnt_reg          <= '0;
            red_in_valid_reg <= 1'b0;
            red_data_in_reg  <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_src_reg      <= 1'b0;
            rsp_tag_reg      <= '0;
            rsp_x_reg        <= '0;
            rsp_q_reg        <= '0;
            rsp_f_reg        <= '0;
            rsp_flags_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        rr_reg      <= ~grant_idx;
                        rsp_src_reg <= grant_idx;
                        rsp_tag_reg <= sel_tag;
                        rsp_x_reg   <= sel_data;
                        rsp_q_reg   <= '0;
                        rsp_f_reg   <= '0;
                        if (sel_exp == 8'hFF) begin
                            // Inf/NaN: no meaningful reduction exists
                            rsp_flags_reg <= 3'b010;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else if (sel_exp < 8'd150) begin
                            // Below 2^23 the reducer's table index would wrap
                            rsp_flags_reg <= 3'b001;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            rsp_flags_reg    <= 3'b000;
                            red_in_valid_reg <= 1'b1;
                            red_data_in_reg  <= sel_data;
                            state_reg        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    red_in_valid_reg <= 1'b0;
                    cnt_reg          <= '0;
                    state_reg        <= WAIT;
                end
                WAIT: begin
                    // A real result beats a watchdog expiry in the same cycle
                    if (red_out_valid) begin
                        rsp_q_reg     <= red_q;
                        rsp_f_reg     <= red_f;
                        rsp_flags_reg <= 3'b000;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        rsp_q_reg     <= '0;
                        rsp_f_reg     <= '0;
                        rsp_flags_reg <= 3'b100;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reducer_request_scheduler.sv
// Directed bench for reducer_request_scheduler with a 4-cycle reducer model.
module tb_reducer_request_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_data;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_data;
    logic [3:0]  req1_tag;
    logic        red_in_valid;
    logic [31:0] red_data_in;
    logic        red_out_valid;
    logic [4:0]  red_q;
    logic [63:0] red_f;
    logic        rsp_valid, rsp_ready, rsp_src;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_x;
    logic [4:0]  rsp_q;
    logic [63:0] rsp_f;
    logic [2:0]  rsp_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reducer model: out_valid four cycles after in_valid, result derived from the held operand
    logic [3:0] pipe = 4'b0;
    logic       model_en = 1'b1;
    logic       late_pulse = 1'b0;

    always @(posedge clk) pipe <= {pipe[2:0], red_in_valid};
    assign red_out_valid = (model_en & pipe[3]) | late_pulse;
    assign red_q = red_data_in[4:0] ^ 5'h0A;
    assign red_f = {red_data_in, ~red_data_in};

    always #5 clk = ~clk;

    reducer_request_scheduler #(.TAG_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
        .red_in_valid(red_in_valid), .red_data_in(red_data_in),
        .red_out_valid(red_out_valid), .red_q(red_q), .red_f(red_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
        .rsp_x(rsp_x), .rsp_q(rsp_q), .rsp_f(rsp_f), .rsp_flags(rsp_flags), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for one cycle; returns in cycle 1 after the handshake
    task automatic send(input bit idx, input logic [31:0] d, input logic [3:0] t);
        if (idx) begin req1_valid = 1'b1; req1_data = d; req1_tag = t; end
        else     begin req0_valid = 1'b1; req0_data = d; req0_tag = t; end
        #1;
        check("send_ready", idx ? req1_ready : req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    // Step until rsp_valid or budget expires; returns number of steps taken
    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        check("rsp_arrived", rsp_valid, 1'b1);
        $display("rsp src=%0d tag=%0h x=%08h q=%0h f=%016h flags=%03b", rsp_src, rsp_tag, rsp_x, rsp_q, rsp_f, rsp_flags);
    endtask

    // Operand answered directly without touching the reducer
    task automatic bypass_case(input bit idx, input logic [31:0] d, input logic [3:0] t,
                               input logic [2:0] exp_flags);
        send(idx, d, t);
        $display("rsp src=%0d tag=%0h x=%08h flags=%03b", rsp_src, rsp_tag, rsp_x, rsp_flags);
        check("byp_valid", rsp_valid, 1'b1);
        check("byp_flags", rsp_flags, exp_flags);
        check("byp_q", rsp_q, 5'd0);
        check("byp_f", rsp_f, 64'd0);
        check("byp_x", rsp_x, d);
        check("byp_src", rsp_src, idx);
        check("byp_tag", rsp_tag, t);
        check("byp_no_issue", red_in_valid, 1'b0);
        check("byp_data_held", red_data_in, 32'h4C800000);
        step();
        check("byp_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int grants[$];
        int rsps;
        int last_issue;
        int bad;

        rst = 1'b1;
        req0_valid = 0; req0_data = 0; req0_tag = 0;
        req1_valid = 0; req1_data = 0; req1_tag = 0;
        rsp_ready = 1'b1;
        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_in_valid", red_in_valid, 1'b0);
        check("rst_data_in", red_data_in, 32'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_flds", {rsp_src, rsp_tag, rsp_x, rsp_q, rsp_flags}, 64'd0);
        check("rst_rsp_f", rsp_f, 64'd0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        rst = 1'b0;
        step();

        // Test 1: nominal reduction timing
        req1_valid = 1'b0;
        #1;
        check("t1_ready1_low", req1_ready, 1'b0);
        send(1'b0, 32'h4B800000, 4'd3);
        check("t1_in_valid_c1", red_in_valid, 1'b1);
        check("t1_data_c1", red_data_in, 32'h4B800000);
        check("t1_busy", busy, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            step();
            check("t1_in_valid_low", red_in_valid, 1'b0);
            check("t1_data_held", red_data_in, 32'h4B800000);
            check("t1_no_rsp_yet", rsp_valid, 1'b0);
        end
        step();
        $display("rsp src=%0d tag=%0h x=%08h q=%0h f=%016h flags=%03b", rsp_src, rsp_tag, rsp_x, rsp_q, rsp_f, rsp_flags);
        check("t1_rsp_c6", rsp_valid, 1'b1);
        check("t1_src", rsp_src, 1'b0);
        check("t1_tag", rsp_tag, 4'd3);
        check("t1_x", rsp_x, 32'h4B800000);
        check("t1_q", rsp_q, 5'h0A);
        check("t1_f", rsp_f, 64'h4B800000B47FFFFF);
        check("t1_flags", rsp_flags, 3'b000);
        step();
        check("t1_rsp_done", rsp_valid, 1'b0);
        check("t1_idle", busy, 1'b0);

        // Test 2: contention from reset alternates grants, issues never closer than 5 cycles
        rst = 1'b1; step(); rst = 1'b0; step();
        req0_valid = 1; req0_data = 32'h4C000000; req0_tag = 4'd5;
        req1_valid = 1; req1_data = 32'h4C800000; req1_tag = 4'd9;
        #1;
        rsps = 0;
        last_issue = -100;
        for (int c = 0; c < 80 && rsps < 4; c++) begin
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (red_in_valid) begin
                check("t2_issue_gap", (c - last_issue) > 4, 1'b1);
                last_issue = c;
            end
            if (rsp_valid) begin
                $display("rsp src=%0d tag=%0h x=%08h flags=%03b", rsp_src, rsp_tag, rsp_x, rsp_flags);
                check("t2_rsp_src", rsp_src, rsps[0]);
                check("t2_rsp_tag", rsp_tag, rsps[0] ? 4'd9 : 4'd5);
                rsps++;
            end
            step();
            if (grants.size() >= 4) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            #1;
        end
        check("t2_rsp_count", rsps, 4);
        check("t2_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check("t2_grant_order", grants[i], i % 2);
        step();

        // Test 3/4: bypass and invalid operands
        bypass_case(1'b1, 32'h3F800000, 4'd7, 3'b001);
        bypass_case(1'b0, 32'h7FC00000, 4'd1, 3'b010);
        bypass_case(1'b0, 32'h7F800000, 4'd2, 3'b010);

        // Test 5: watchdog expiry, then a late out_valid is ignored
        model_en = 1'b0;
        send(1'b0, 32'h4B800001, 4'd2);
        bad = 0;
        for (int k = 2; k <= 16; k++) begin
            step();
            if (rsp_valid) bad++;
        end
        check("t5_no_early_rsp", bad, 0);
        step();
        $display("rsp src=%0d tag=%0h x=%08h flags=%03b", rsp_src, rsp_tag, rsp_x, rsp_flags);
        check("t5_rsp_c17", rsp_valid, 1'b1);
        check("t5_flags", rsp_flags, 3'b100);
        check("t5_q", rsp_q, 5'd0);
        check("t5_f", rsp_f, 64'd0);
        check("t5_tag", rsp_tag, 4'd2);
        step();
        step();
        late_pulse = 1'b1;
        step();
        late_pulse = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid || busy) bad++;
            step();
        end
        check("t5_late_ignored", bad, 0);
        model_en = 1'b1;

        // Test 6: back-pressure holds the response and blocks new grants
        rsp_ready = 1'b0;
        send(1'b1, 32'h4D000000, 4'd4);
        wait_rsp(20, n);
        check("t6_latency", n, 5);
        req0_valid = 1; req0_data = 32'h4C000000; req0_tag = 4'd8;
        req1_valid = 1; req1_data = 32'h4C800000; req1_tag = 4'd8;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t6_hold_flds", {rsp_valid, rsp_src, rsp_tag, rsp_x, rsp_q, rsp_flags},
                  {1'b1, 1'b1, 4'd4, 32'h4D000000, 5'h0A, 3'b000});
            check("t6_hold_f", rsp_f, 64'h4D000000B2FFFFFF);
            check("t6_ready_low", {req0_ready, req1_ready}, 2'b00);
            step();
        end
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready = 1'b1;
        step();
        check("t6_released", rsp_valid, 1'b0);

        // Reset during WAIT drops the operation; the stale reducer pulse is ignored
        send(1'b0, 32'h4B800000, 4'd1);
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_rsp", rsp_valid, 1'b0);
        check("t6_rst_in_valid", red_in_valid, 1'b0);
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (rsp_valid || busy) bad++;
        end
        check("t6_no_stale_rsp", bad, 0);
        send(1'b1, 32'h4B800000, 4'd6);
        wait_rsp(20, n);
        check("t6_post_latency", n, 5);
        check("t6_post_src", rsp_src, 1'b1);
        check("t6_post_tag", rsp_tag, 4'd6);
        check("t6_post_q", rsp_q, 5'h0A);
        check("t6_post_f", rsp_f, 64'h4B800000B47FFFFF);
        check("t6_post_flags", rsp_flags, 3'b000);
        step();
        check("t6_post_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
